// File: rtl/pipe_seq_ctrl.sv
// rtl/pipe_seq_ctrl.sv - pipeline sequencing controller: hazard stall, branch flush, data-memory wait FSM
module pipe_seq_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_RegDest,
  input  logic             ex_branch_taken,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_ld,
  output logic             if_id_ld,
  output logic             id_ex_ld,
  output logic             ex_mem_ld,
  output logic             mem_wb_ld,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DONE, S_ERR} state_t;

  // Wait counter holds the number of WAIT cycles already completed, so the
  // MEM_TIMEOUT-th WAIT cycle is the one where it equals MEM_TIMEOUT-1.
  localparam logic [15:0] LP_LAST_WAIT = 16'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_wait_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_op;
  logic w_load_use;
  logic w_freeze;
  logic w_timeout;

  assign w_mem_op   = mem_MemRead | mem_MemWrite;
  assign w_load_use = ex_MemRead & (ex_RegDest != 5'd0) &
                      ((ex_RegDest == id_rs) | (id_uses_rt & (ex_RegDest == id_rt)));
  assign w_freeze   = ((r_state == S_RUN) & w_mem_op) | (r_state == S_WAIT) | (r_state == S_ERR);
  assign w_timeout  = (r_wait_cnt == LP_LAST_WAIT);

  assign err       = r_err;
  assign stall_cnt = r_stall_cnt;

  // State register, wait counter, sticky error flag and stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= 16'd0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end else begin
        r_wait_cnt <= 16'd0;
      end
      r_err <= (w_next == S_ERR);
      if (!pc_ld && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state logic; ack wins over timeout in the same WAIT cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN:   if (w_mem_op) w_next = S_WAIT;
      S_WAIT: begin
        if (dmem_ack)       w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DONE:  w_next = S_RUN;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_RUN;
    endcase
  end

  // Pipeline controls: freeze > branch > load-use > normal, all zero in reset
  always_comb begin
    dmem_req      = (r_state == S_WAIT);
    pc_ld         = 1'b1;
    if_id_ld      = 1'b1;
    id_ex_ld      = 1'b1;
    ex_mem_ld     = 1'b1;
    mem_wb_ld     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (w_freeze) begin
      pc_ld         = 1'b0;
      if_id_ld      = 1'b0;
      id_ex_ld      = 1'b0;
      ex_mem_ld     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (w_load_use) begin
      pc_ld         = 1'b0;
      if_id_ld      = 1'b0;
      id_ex_flush   = 1'b1;
    end
    if (!rst) begin
      dmem_req      = 1'b0;
      pc_ld         = 1'b0;
      if_id_ld      = 1'b0;
      id_ex_ld      = 1'b0;
      ex_mem_ld     = 1'b0;
      mem_wb_ld     = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
    end
  end

endmodule

// File: doc/pipe_seq_ctrl.md
# pipe_seq_ctrl

Pipeline sequencing controller for the 5-stage datapath. It generates the load-enable, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards and taken-branch flushes, and it sequences multi-cycle data-memory accesses through a req/ack handshake with a timeout. It sits beside the datapath, taking decoded fields from ID, EX and MEM and driving the register `ld`/clear inputs.

## Interface
- MEM_TIMEOUT, 255: maximum WAIT cycles before the error trap; 1..65535.
- CNT_W, 16: width of the stall counter.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_MemRead  in  1  the instruction in EX is a load.
- ex_RegDest  in  5  destination of the instruction in EX.
- ex_branch_taken  in  1  a branch in EX resolved taken.
- mem_MemRead, mem_MemWrite  in  1 each  the instruction in MEM accesses data memory.
- dmem_ack  in  1  data memory completed the request.
- dmem_req  out  1  data memory request.
- pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld  out  1 each  register load enables.
- if_id_flush, id_ex_flush  out  1 each  synchronous clear: register loads a NOP.
- mem_wb_bubble  out  1  MEM/WB loads wb_RegWrite=0 and wb_MemToReg=0.
- err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_ld=0.

## Operation
- FSM states: RUN, WAIT, DONE, ERR. Reset state is RUN.
- `mem_op = mem_MemRead | mem_MemWrite`.
- `load_use = ex_MemRead & (ex_RegDest != 0) & ((ex_RegDest == id_rs) | (id_uses_rt & ex_RegDest == id_rt))`.
- `freeze = (RUN & mem_op) | WAIT | ERR`.
- Output priority (highest first): freeze > ex_branch_taken > load_use > normal.
  - **freeze:** pc_ld, if_id_ld, id_ex_ld and ex_mem_ld are 0. mem_wb_ld=1 with mem_wb_bubble=1, so the older instruction already in MEM/WB writes back exactly once. No flushes.
  - **branch (not freeze):** all ld=1, if_id_flush=1, id_ex_flush=1.
  - **load_use (no freeze, no branch):** pc_ld=0, if_id_ld=0, id_ex_ld=1 with id_ex_flush=1 (bubble), ex_mem_ld=1, mem_wb_ld=1.
  - **normal:** all ld=1, no flush, no bubble.
- dmem_req = 1 only in WAIT.
- Transitions:
  - RUN → WAIT if mem_op, else RUN.
  - WAIT → DONE on dmem_ack.
  - WAIT → ERR when the wait counter reaches MEM_TIMEOUT without dmem_ack. dmem_ack has priority over timeout in the same cycle.
  - DONE → RUN unconditionally. DONE is never frozen; its outputs follow branch/load_use/normal priority. This moves the serviced instruction into MEM/WB, so it is not re-detected as a new mem_op.
  - ERR is terminal until rst. err=1 in ERR.
- Wait counter: cleared on entry to WAIT, increments once per WAIT cycle.
- stall_cnt: increments each cycle pc_ld=0, saturates at all-ones, cleared only by reset.
- dmem_ack outside WAIT is ignored.

## Timing
- rst low, asynchronous: state=RUN, wait counter=0, stall_cnt=0, err=0. While rst is low all outputs are forced to 0 (every ld, flush, bubble and dmem_req).
- After release, outputs are combinational from state plus current inputs. There are no registered outputs except err and stall_cnt.
- Memory op latency: detect cycle (RUN) + N WAIT cycles (ack in the Nth, N≥1) + DONE. The pipeline freezes for 1+N cycles; instructions advance in the DONE cycle.
- Zero-wait memory (ack already high on WAIT entry): exactly 2 frozen cycles.
- Reset asserted mid-WAIT: dmem_req drops immediately (asynchronous); after release the FSM is in RUN.
- Load-use stall lasts 1 cycle: next cycle the load is in MEM, so freeze takes over.

## Test plan
- **Load-use:** ex_MemRead=1, ex_RegDest=5, id_rs=5 → pc_ld=0, if_id_ld=0, id_ex_flush=1 for one cycle. Same with ex_RegDest=0 → no stall.
- **Branch vs load-use:** ex_branch_taken=1 with load_use also true → if_id_flush=1, id_ex_flush=1, pc_ld=1. Branch during freeze → flushes suppressed until DONE.
- **Memory wait:** mem_MemRead=1, ack after 3 WAIT cycles → dmem_req high for exactly 3 cycles, mem_wb_bubble=1 for 4 cycles, all ld=1 in DONE, stall_cnt +4.
- **Zero-wait:** ack held high → RUN→WAIT→DONE→RUN, dmem_req for 1 cycle.
- **Timeout:** MEM_TIMEOUT=4, no ack → ERR after 4 WAIT cycles, err=1 and pipeline frozen permanently. Ack on the 4th cycle → DONE, err stays 0.
- **Reset:** rst low during WAIT → dmem_req=0 and all ld=0 immediately, stall_cnt=0. After release with no mem_op → normal flow.
